bsg_link_channel_rx_assembler: RTL and testbench



---
 rtl/bsg_link_rx_pkg.sv | 16 +
 rtl/bsg_link_channel_rx_assembler_if.sv | 19 +
 rtl/bsg_link_rx_fifo.sv | 34 +++
 rtl/bsg_link_channel_rx_assembler.sv | 74 +++++++
 tb/tb_bsg_link_channel_rx_assembler.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/bsg_link_rx_pkg.sv
// bsg_link_rx_pkg: shared widths, word type and sizing helper for the link channel receiver.
package bsg_link_rx_pkg;
   localparam int channel_width_lp    = 8;
   localparam int beats_lp            = 5;
   localparam int word_width_lp       = channel_width_lp*beats_lp;
   localparam int fifo_els_lp         = 8;
   localparam int token_decimation_lp = 4;
   localparam int fifo_ptr_width_lp   = $clog2(fifo_els_lp)+1;

   typedef logic [word_width_lp-1:0] link_word_t;

   // Counter width that never collapses to zero bits.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/bsg_link_channel_rx_assembler_if.sv
// bsg_link_channel_rx_assembler_if: link beat input, core word handshake and credit token.
interface bsg_link_channel_rx_assembler_if
   import bsg_link_rx_pkg::*;
#(
   parameter int channel_width_p = channel_width_lp,
   parameter int beats_p         = beats_lp
);
   logic                               io_valid_i;
   logic [channel_width_p-1:0]         io_data_i;
   logic                               core_valid_o;
   logic [channel_width_p*beats_p-1:0] core_data_o;
   logic                               core_yumi_i;
   logic                               token_o;

   modport master (output io_valid_i, io_data_i, core_yumi_i,
                   input  core_valid_o, core_data_o, token_o);
   modport slave  (input  io_valid_i, io_data_i, core_yumi_i,
                   output core_valid_o, core_data_o, token_o);
endinterface

// File: rtl/bsg_link_rx_fifo.sv
// bsg_link_rx_fifo: circular FIFO with wrap-bit pointers; full-with-dequeue still accepts the write.
module bsg_link_rx_fifo #(
   parameter int width_p = 40,
   parameter int els_p   = 8
) (
   input  logic               clk_i,
   input  logic               async_reset_n_i,
   input  logic               enq_i,
   input  logic [width_p-1:0] data_i,
   input  logic               deq_i,
   output logic [width_p-1:0] data_o,
   output logic               full_o,
   output logic               empty_o
);
   localparam int aw = $clog2(els_p);
   logic [aw:0]        rptr, wptr;
   logic [width_p-1:0] mem [els_p];
   logic               deq, enq;
   assign empty_o = rptr == wptr;
   assign full_o  = rptr[aw-1:0] == wptr[aw-1:0] && rptr[aw] != wptr[aw];
   assign deq     = deq_i && !empty_o;
   assign enq     = enq_i && (!full_o || deq);
   assign data_o  = mem[rptr[aw-1:0]];
   always_ff @(posedge clk_i)
      if (enq) mem[wptr[aw-1:0]] <= data_i;
   always_ff @(posedge clk_i or negedge async_reset_n_i)
      if (!async_reset_n_i) begin
         rptr <= '0;
         wptr <= '0;
      end else begin
         if (enq) wptr <= wptr + (aw+1)'(1);
         if (deq) rptr <= rptr + (aw+1)'(1);
      end
endmodule

// File: rtl/bsg_link_channel_rx_assembler.sv
// bsg_link_channel_rx_assembler: gathers link beats into core words, buffers them and returns decimated credit tokens.
module bsg_link_channel_rx_assembler
   import bsg_link_rx_pkg::*;
#(
   parameter int channel_width_p    = channel_width_lp,
   parameter int beats_p            = beats_lp,
   parameter int fifo_els_p         = fifo_els_lp,
   parameter int token_decimation_p = token_decimation_lp
) (
   input  logic                       clk_i,
   input  logic                       async_reset_n_i,
   bsg_link_channel_rx_assembler_if.slave link,
   output logic                       overflow_o,
   output logic [cw(beats_p)-1:0]     beat_cnt_o
);
   localparam int ww = channel_width_p*beats_p;
   localparam int bw = cw(beats_p);
   localparam int dw = cw(token_decimation_p);

   if (fifo_els_p < 2 || (fifo_els_p & (fifo_els_p-1)) != 0 || fifo_els_p % token_decimation_p != 0) begin : g_bad_params
      $error("fifo_els_p must be a power of two >= 2 and a multiple of token_decimation_p");
   end

   logic [channel_width_p-1:0] partial [beats_p-1];
   logic [ww-1:0]              word, head;
   logic                       last, deq, full, empty, token;
   logic [dw-1:0]              dec_cnt;

   assign last = link.io_valid_i && beat_cnt_o == bw'(beats_p-1);
   assign deq  = link.core_yumi_i && !empty;
   assign link.core_valid_o = !empty;
   assign link.core_data_o  = head;
   assign link.token_o      = token;

   // The final beat bypasses the partial store so the word enqueues in the same cycle.
   always_comb begin
      word = '0;
      for (int k = 0; k < beats_p-1; k++) word[k*channel_width_p +: channel_width_p] = partial[k];
      word[ww-1 -: channel_width_p] = link.io_data_i;
   end

   always_ff @(posedge clk_i)
      for (int k = 0; k < beats_p-1; k++)
         if (link.io_valid_i && beat_cnt_o == bw'(k)) partial[k] <= link.io_data_i;

   always_ff @(posedge clk_i or negedge async_reset_n_i)
      if (!async_reset_n_i) begin
         beat_cnt_o <= '0;
         overflow_o <= 1'b0;
         dec_cnt    <= '0;
         token      <= 1'b0;
      end else begin
         if (link.io_valid_i) beat_cnt_o <= last ? '0 : beat_cnt_o + bw'(1);
         if (last && full && !link.core_yumi_i) overflow_o <= 1'b1;
         if (deq) begin
            dec_cnt <= (dec_cnt == dw'(token_decimation_p-1)) ? '0 : dec_cnt + dw'(1);
            if (dec_cnt == dw'(token_decimation_p-1)) token <= ~token;
         end
      end

   bsg_link_rx_fifo #(.width_p(ww), .els_p(fifo_els_p)) fifo (
      .clk_i          (clk_i),
      .async_reset_n_i(async_reset_n_i),
      .enq_i          (last),
      .data_i         (word),
      .deq_i          (link.core_yumi_i),
      .data_o         (head),
      .full_o         (full),
      .empty_o        (empty)
   );

   a_yumi_legal: assert property (@(posedge clk_i) disable iff (!async_reset_n_i)
      link.core_yumi_i |-> link.core_valid_o);
endmodule

// File: tb/tb_bsg_link_channel_rx_assembler.sv
// tb_bsg_link_channel_rx_assembler: directed and random stimulus against a queue-based reference model.
module tb_bsg_link_channel_rx_assembler;
   import bsg_link_rx_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ovf;
   logic [2:0] bc;
   int         total = 0;
   int         bad = 0;

   logic [7:0] part[$];
   link_word_t mq[$];
   int         nyumi = 0;
   bit         m_ovf = 0;

   bsg_link_channel_rx_assembler_if bus ();

   bsg_link_channel_rx_assembler dut (
      .clk_i          (clk),
      .async_reset_n_i(rst_n),
      .link           (bus),
      .overflow_o     (ovf),
      .beat_cnt_o     (bc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("core_valid", 64'(bus.core_valid_o), 64'(mq.size() > 0));
      if (mq.size() > 0) chk("core_data", 64'(bus.core_data_o), 64'(mq[0]));
      chk("token", 64'(bus.token_o), 64'((nyumi/4) % 2));
      chk("overflow", 64'(ovf), 64'(m_ovf));
      chk("beat_cnt", 64'(bc), 64'(part.size()));
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic y);
      bit deq = y && (mq.size() > 0);
      int occ = mq.size();
      if (deq) begin
         void'(mq.pop_front());
         nyumi++;
      end
      if (v) begin
         part.push_back(d);
         if (part.size() == 5) begin
            link_word_t w = '0;
            for (int k = 0; k < 5; k++) w[k*8 +: 8] = part[k];
            if (occ == 8 && !deq) m_ovf = 1;
            else mq.push_back(w);
            part.delete();
         end
      end
   endtask

   // Called at a falling edge: check current state, drive inputs, advance one clock.
   task automatic cycle(input logic v, input logic [7:0] d, input logic y);
      check_model();
      bus.io_valid_i  = v;
      bus.io_data_i   = d;
      bus.core_yumi_i = y && (mq.size() > 0);
      model_step(v, d, bus.core_yumi_i);
      @(negedge clk);
   endtask

   task automatic send_word(input logic [39:0] w, input logic y_last);
      for (int k = 0; k < 5; k++) cycle(1'b1, w[k*8 +: 8], (k == 4) ? y_last : 1'b0);
   endtask

   task automatic reset_pulse();
      #2;
      rst_n = 1'b0;
      bus.io_valid_i  = 1'b0;
      bus.core_yumi_i = 1'b0;
      #1;
      chk("rst_valid", 64'(bus.core_valid_o), 64'(0));
      chk("rst_token", 64'(bus.token_o), 64'(0));
      chk("rst_beat_cnt", 64'(bc), 64'(0));
      chk("rst_overflow", 64'(ovf), 64'(0));
      part.delete();
      mq.delete();
      nyumi = 0;
      m_ovf = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.io_valid_i  = 1'b0;
      bus.io_data_i   = '0;
      bus.core_yumi_i = 1'b0;
      @(negedge clk);
      reset_pulse();

      // single word
      send_word(40'h55_44_33_22_11, 1'b0);
      chk("single_valid", 64'(bus.core_valid_o), 64'(1));
      chk("single_data", 64'(bus.core_data_o), 64'h55_44_33_22_11);
      cycle(1'b0, 8'h00, 1'b1);

      // gapped beats
      cycle(1'b1, 8'h11, 1'b0);
      cycle(1'b1, 8'h22, 1'b0);
      cycle(1'b1, 8'h33, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("gap_beat_cnt", 64'(bc), 64'(3));
         cycle(1'b0, 8'($urandom), 1'b0);
      end
      cycle(1'b1, 8'h44, 1'b0);
      cycle(1'b1, 8'h55, 1'b0);
      chk("gap_data", 64'(bus.core_data_o), 64'h55_44_33_22_11);
      cycle(1'b0, 8'h00, 1'b1);

      // fill and overflow
      reset_pulse();
      for (int i = 0; i < 9; i++) begin
         if (i == 8) chk("pre_overflow", 64'(ovf), 64'(0));
         send_word({$urandom, 8'($urandom)}, 1'b0);
      end
      chk("overflow_set", 64'(ovf), 64'(1));
      for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
      chk("drained_empty", 64'(bus.core_valid_o), 64'(0));
      chk("overflow_sticky", 64'(ovf), 64'(1));

      // full with simultaneous dequeue
      reset_pulse();
      for (int i = 0; i < 8; i++) send_word({$urandom, 8'($urandom)}, 1'b0);
      send_word(40'hCA_FE_BE_EF_01, 1'b1);
      chk("full_deq_ovf", 64'(ovf), 64'(0));
      for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
      chk("full_deq_last", 64'(bus.core_data_o), 64'hCA_FE_BE_EF_01);
      cycle(1'b0, 8'h00, 1'b1);

      // tokens
      reset_pulse();
      for (int i = 0; i < 8; i++) send_word({$urandom, 8'($urandom)}, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b0, 8'h00, 1'b1);
         if (i == 3) chk("token_before_4", 64'(bus.token_o), 64'(0));
         if (i == 4) chk("token_after_4", 64'(bus.token_o), 64'(1));
         if (i == 8) chk("token_after_8", 64'(bus.token_o), 64'(0));
      end
      for (int i = 0; i < 4; i++) send_word({$urandom, 8'($urandom)}, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
      chk("token_after_12", 64'(bus.token_o), 64'(1));

      // reset mid-word with words queued
      for (int i = 0; i < 3; i++) send_word({$urandom, 8'($urandom)}, 1'b0);
      cycle(1'b1, 8'($urandom), 1'b0);
      cycle(1'b1, 8'($urandom), 1'b0);
      reset_pulse();
      send_word(40'hA5_A4_A3_A2_A1, 1'b0);
      chk("post_reset_valid", 64'(bus.core_valid_o), 64'(1));
      chk("post_reset_data", 64'(bus.core_data_o), 64'hA5_A4_A3_A2_A1);

      // random traffic, occasionally saturating the FIFO
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
      check_model();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
